// File: rtl/a23_copro15_ctrl.sv
// CP15 controller for the Amber 23 core: cache control and region registers,
// request/acknowledge flush sequencer and a fault capture FIFO.
module a23_copro15_ctrl #(
  parameter int          REGION_SHIFT = 21,
  parameter int          FAULT_DEPTH  = 4,
  parameter logic [31:0] CORE_ID      = 32'h4156_0300
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_stall,
  input  logic [3:0]  i_copro_num,
  input  logic [1:0]  i_copro_operation,
  input  logic [3:0]  i_copro_crn,
  input  logic [31:0] i_copro_write_data,
  input  logic        i_fault,
  input  logic [7:0]  i_fault_status,
  input  logic [31:0] i_fault_address,
  input  logic        i_access_valid,
  input  logic        i_access_write,
  input  logic [31:0] i_access_address,
  input  logic        i_flush_done,
  output logic [31:0] o_copro_read_data,
  output logic        o_cache_enable,
  output logic        o_cache_flush,
  output logic        o_flush_busy,
  output logic [31:0] o_cacheable_area,
  output logic        o_access_cacheable,
  output logic        o_access_updateable
);
  localparam int PW = $clog2(FAULT_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, FLUSH} flush_state_t;

  flush_state_t r_state;
  logic         r_pending;
  logic [2:0]   r_cache_control;
  logic [31:0]  r_cacheable, r_updateable, r_disruptive;
  logic [31:0]  r_read_data;
  logic         r_acc_cacheable, r_acc_updateable;
  logic [7:0]   r_fault_status  [FAULT_DEPTH];
  logic [31:0]  r_fault_address [FAULT_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic        w_dec, w_wr, w_rd, w_in_range, w_req, w_disrupt;
  logic        w_push, w_pop, w_full, w_empty;
  logic [4:0]  w_idx;
  logic [7:0]  w_head_status;
  logic [31:0] w_head_address, w_rd_mux;

  assign w_dec = !i_fetch_stall && (i_copro_num == 4'd15);
  assign w_wr  = w_dec && (i_copro_operation == 2'd2);
  assign w_rd  = w_dec && (i_copro_operation == 2'd1);

  // Addresses beyond the 32 covered regions never match any region bit.
  assign w_idx      = i_access_address[REGION_SHIFT+4:REGION_SHIFT];
  assign w_in_range = (i_access_address >> (REGION_SHIFT + 5)) == 32'd0;

  assign w_disrupt = i_access_valid && i_access_write && w_in_range &&
                     r_disruptive[w_idx] && r_cache_control[0] && !i_fetch_stall;
  assign w_req     = (w_wr && (i_copro_crn == 4'd1)) || w_disrupt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FAULT_DEPTH));
  assign w_push  = i_fault && !i_fetch_stall;
  assign w_pop   = w_wr && (i_copro_crn == 4'd6) && !w_empty;

  assign w_head_status  = w_empty ? 8'd0  : r_fault_status[r_rd_ptr];
  assign w_head_address = w_empty ? 32'd0 : r_fault_address[r_rd_ptr];

  always_comb begin
    w_rd_mux = 32'd0;
    case (i_copro_crn)
      4'd0:    w_rd_mux = CORE_ID;
      4'd2:    w_rd_mux = {29'd0, r_cache_control};
      4'd3:    w_rd_mux = r_cacheable;
      4'd4:    w_rd_mux = r_updateable;
      4'd5:    w_rd_mux = r_disruptive;
      4'd6:    w_rd_mux = {r_overflow, 7'd0, {{(8-CW){1'b0}}, r_count}, 8'd0, w_head_status};
      4'd7:    w_rd_mux = w_head_address;
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cache_control  <= '0;
      r_cacheable      <= '0;
      r_updateable     <= '0;
      r_disruptive     <= '0;
      r_read_data      <= '0;
      r_acc_cacheable  <= 1'b0;
      r_acc_updateable <= 1'b0;
    end else begin
      if (w_rd) r_read_data <= w_rd_mux;
      if (w_wr) begin
        case (i_copro_crn)
          4'd2:    r_cache_control <= i_copro_write_data[2:0];
          4'd3:    r_cacheable     <= i_copro_write_data;
          4'd4:    r_updateable    <= i_copro_write_data;
          4'd5:    r_disruptive    <= i_copro_write_data;
          default: ;
        endcase
      end
      if (i_access_valid && !i_fetch_stall) begin
        r_acc_cacheable  <= w_in_range && r_cacheable[w_idx];
        r_acc_updateable <= w_in_range && r_updateable[w_idx];
      end
    end
  end

  // A request during FLUSH, even alongside i_flush_done, restarts with no gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req) r_state <= FLUSH;
        FLUSH: begin
          if (i_flush_done) begin
            if (r_pending) r_pending <= w_req;
            else if (!w_req) r_state <= IDLE;
          end else if (w_req) begin
            r_pending <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FAULT_DEPTH; i++) begin
        r_fault_status[i]  <= '0;
        r_fault_address[i] <= '0;
      end
    end else begin
      if (w_wr && (i_copro_crn == 4'd6)) r_overflow <= 1'b0;
      if (w_push && (!w_full || w_pop)) begin
        r_fault_status[r_wr_ptr]  <= i_fault_status;
        r_fault_address[r_wr_ptr] <= i_fault_address;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end else if (w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_full && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)       r_count <= r_count - 1'b1;
    end
  end

  assign o_copro_read_data   = r_read_data;
  assign o_cache_enable      = r_cache_control[0];
  assign o_cache_flush       = (r_state == FLUSH);
  assign o_flush_busy        = (r_state == FLUSH);
  assign o_cacheable_area    = r_cacheable;
  assign o_access_cacheable  = r_acc_cacheable;
  assign o_access_updateable = r_acc_updateable;
endmodule

// File: tb/tb_a23_copro15_ctrl.sv
// Bench for a23_copro15_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_a23_copro15_ctrl;
  localparam int          RS    = 21;
  localparam int          DEPTH = 4;
  localparam logic [31:0] CID   = 32'h4156_0300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  num = 4'd0;
  logic [1:0]  op = 2'd0;
  logic [3:0]  crn = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        fault = 1'b0;
  logic [7:0]  fstatus = 8'd0;
  logic [31:0] faddr = 32'd0;
  logic        avalid = 1'b0;
  logic        awrite = 1'b0;
  logic [31:0] aaddr = 32'd0;
  logic        done = 1'b0;

  logic [31:0] rdata, carea;
  logic        cen, cflush, fbusy, acc_c, acc_u;

  a23_copro15_ctrl #(.REGION_SHIFT(RS), .FAULT_DEPTH(DEPTH), .CORE_ID(CID)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_stall(stall),
    .i_copro_num(num), .i_copro_operation(op), .i_copro_crn(crn),
    .i_copro_write_data(wdata), .i_fault(fault), .i_fault_status(fstatus),
    .i_fault_address(faddr), .i_access_valid(avalid), .i_access_write(awrite),
    .i_access_address(aaddr), .i_flush_done(done),
    .o_copro_read_data(rdata), .o_cache_enable(cen), .o_cache_flush(cflush),
    .o_flush_busy(fbusy), .o_cacheable_area(carea),
    .o_access_cacheable(acc_c), .o_access_updateable(acc_u)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // reference model state
  logic [2:0]  m_cc;
  logic [31:0] m_cach, m_upd, m_dis;
  logic        m_acc_c, m_acc_u, m_ovf;
  int          m_owed;              // flushes still owed to the cache: 0, 1 or 2
  logic [7:0]  st_q[$];
  logic [31:0] ad_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] read_val(input logic [3:0] c);
    case (c)
      4'd0: return CID;
      4'd2: return {29'd0, m_cc};
      4'd3: return m_cach;
      4'd4: return m_upd;
      4'd5: return m_dis;
      4'd6: return {m_ovf, 7'd0, 8'(st_q.size()), 8'd0, (st_q.size() > 0) ? st_q[0] : 8'd0};
      4'd7: return (ad_q.size() > 0) ? ad_q[0] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_cc = '0; m_cach = '0; m_upd = '0; m_dis = '0;
    m_acc_c = 0; m_acc_u = 0; m_ovf = 0; m_owed = 0;
    st_q.delete(); ad_q.delete(); exp_q.delete();
  endtask

  // Apply one clock edge worth of the rules to the model, from current inputs.
  task automatic model_edge();
    bit wr, rd, in_range, req;
    int idx, owed;
    rd = !stall && num == 4'd15 && op == 2'd1;
    wr = !stall && num == 4'd15 && op == 2'd2;
    if (rd) exp_q.push_back(read_val(crn));
    idx = int'((aaddr >> RS) & 32'd31);
    in_range = (aaddr >> (RS + 5)) == 32'd0;
    req = (wr && crn == 4'd1) ||
          (avalid && awrite && !stall && in_range && m_dis[idx] && m_cc[0]);
    if (avalid && !stall) begin
      m_acc_c = in_range && m_cach[idx];
      m_acc_u = in_range && m_upd[idx];
    end
    owed = m_owed;
    if (done && owed > 0) owed--;
    if (req) owed++;
    m_owed = (owed > 2) ? 2 : owed;
    if (wr && crn == 4'd6) begin
      m_ovf = 0;
      if (st_q.size() > 0) begin
        void'(st_q.pop_front());
        void'(ad_q.pop_front());
      end
    end
    if (fault && !stall) begin
      if (st_q.size() < DEPTH) begin
        st_q.push_back(fstatus);
        ad_q.push_back(faddr);
      end else m_ovf = 1;
    end
    if (wr) begin
      case (crn)
        4'd2: m_cc = wdata[2:0];
        4'd3: m_cach = wdata;
        4'd4: m_upd = wdata;
        4'd5: m_dis = wdata;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("cache_flush", {31'd0, cflush}, {31'd0, m_owed > 0});
    chk("flush_busy", {31'd0, fbusy}, {31'd0, m_owed > 0});
    chk("cache_enable", {31'd0, cen}, {31'd0, m_cc[0]});
    chk("cacheable_area", carea, m_cach);
    chk("access_cacheable", {31'd0, acc_c}, {31'd0, m_acc_c});
    chk("access_updateable", {31'd0, acc_u}, {31'd0, m_acc_u});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic clr();
    stall = 0; num = 0; op = 0; crn = 0; wdata = 0; fault = 0;
    avalid = 0; awrite = 0; done = 0;
  endtask

  task automatic mcr(input logic [3:0] c, input logic [31:0] d);
    num = 4'd15; op = 2'd2; crn = c; wdata = d; step(); clr();
  endtask

  task automatic mrc(input logic [3:0] c);
    num = 4'd15; op = 2'd1; crn = c; step(); clr();
  endtask

  task automatic access(input logic wr, input logic [31:0] a);
    avalid = 1; awrite = wr; aaddr = a; step(); clr();
  endtask

  task automatic push_fault(input logic [7:0] s, input logic [31:0] a);
    fault = 1; fstatus = s; faddr = a; step(); clr();
  endtask

  task automatic flush_done();
    done = 1; step(); clr();
  endtask

  // Read responses: one registered result follows every accepted MRC.
  logic rd_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_v <= 1'b0;
    else        rd_v <= (num == 4'd15 && op == 2'd1 && !stall);
  end

  always @(negedge clk) begin
    if (rd_v) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL read: got %h with no expected value queued", rdata);
      end else begin
        chk("read_data", rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    clr();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst_read_data", rdata, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // identification and empty fault registers
    mrc(4'd0); mrc(4'd6); mrc(4'd7); step();

    // region lookup
    mcr(4'd3, 32'h0000_0003);
    access(1'b0, 32'h0030_0000); chk("region1_cacheable", {31'd0, acc_c}, 32'd1);
    access(1'b0, 32'h0040_0000); chk("region2_cacheable", {31'd0, acc_c}, 32'd0);
    access(1'b0, 32'h4000_0000); chk("out_of_range", {31'd0, acc_c}, 32'd0);

    // software flush with a second request collapsing into pending
    mcr(4'd1, 32'd0); chk("flush_rise", {31'd0, cflush}, 32'd1);
    step();
    mcr(4'd1, 32'd0);
    flush_done(); chk("flush_no_gap", {31'd0, cflush}, 32'd1);
    step();
    flush_done(); chk("flush_idle", {31'd0, fbusy}, 32'd0);

    // disruptive writes
    mcr(4'd2, 32'd1); mcr(4'd5, 32'd4);
    access(1'b1, 32'h0040_0010); chk("disrupt_flush", {31'd0, cflush}, 32'd1);
    flush_done();
    mcr(4'd2, 32'd0);
    access(1'b1, 32'h0040_0010); chk("disrupt_off", {31'd0, cflush}, 32'd0);

    // fault FIFO overflow and pops
    for (int i = 1; i <= 5; i++) push_fault(8'(i), 32'h1000 * i);
    mrc(4'd6); mrc(4'd7);
    mcr(4'd6, 32'hdead_beef);
    mrc(4'd6);
    for (int i = 0; i < 4; i++) mcr(4'd6, 32'd0);
    mrc(4'd6); mrc(4'd7); step();

    // reset while flushing with two faults stored
    mcr(4'd1, 32'd0);
    push_fault(8'h11, 32'hA000_0000);
    push_fault(8'h22, 32'hB000_0000);
    chk("pre_reset_busy", {31'd0, fbusy}, 32'd1);
    rst_n = 0;
    #1;
    chk("reset_drops_flush", {31'd0, cflush}, 32'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check_outputs();
    mrc(4'd6); mrc(4'd7); step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      stall  = ($urandom_range(0, 5) == 0);
      num    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd15;
      op     = 2'($urandom);
      crn    = 4'($urandom_range(0, 9));
      wdata  = $urandom;
      fault  = ($urandom_range(0, 3) == 0);
      fstatus = 8'($urandom);
      faddr  = $urandom;
      avalid = $urandom_range(0, 1) == 1;
      awrite = $urandom_range(0, 1) == 1;
      aaddr  = ($urandom_range(0, 7) == 0) ? $urandom
             : ((32'($urandom_range(0, 31)) << RS) | 32'($urandom_range(0, 4095)));
      done   = (m_owed > 0) && ($urandom_range(0, 3) == 0);
      step();
    end
    clr();
    repeat (3) step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
